load_store_unit: RTL and testbench
==================================

# load_store_unit

Memory-stage load/store unit sitting directly upstream of `DataMemory`: accepts one load/store request per handshake from the MEM pipeline stage and drives `DataMemory`'s `mem_read`/`mem_write`/`funct3`/`addr`/`write_data` port. Aligned accesses pass through as a single beat. Misaligned halfword/word accesses are split into sequential byte beats, then reassembled and extended for loads. It returns a single-cycle response pulse carrying load data or a fault flag.

## Interface
Parameters:
- `SPLIT_EN`, 1: 1 = split misaligned accesses into byte beats; 0 = misaligned access faults with no memory traffic.

Ports:
- `clk` in 1: system clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: unit idle, able to accept; handshake = `req_valid & req_ready`.
- `req_is_store` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: RV32I width/sign code (000 B, 001 H, 010 W, 100 BU, 101 HU).
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, LSB-justified.
- `resp_valid` out 1: one-cycle completion pulse; no backpressure.
- `resp_rdata` out 32: extended load data (0 for stores and faults).
- `resp_fault` out 1: illegal funct3, or misaligned access with `SPLIT_EN`=0.
- `mem_read` out 1, `mem_write` out 1, `mem_funct3` out 3, `mem_addr` out 32, `mem_wdata` out 32: to `DataMemory`.
- `mem_rdata` in 32: from `DataMemory`; valid the cycle after a `mem_read` cycle (1-cycle read latency).

## Operation
- FSM states: IDLE, ACCESS, CAPTURE, RESP.
- IDLE: `req_ready`=1. A handshake latches the request, computes the beat count N and goes to ACCESS with beat index i=0.
- Misaligned: H with `addr[0]`=1, or W with `addr[1:0]`≠0. B/BU are never misaligned.
- Aligned access: N=1, `mem_funct3`=`req_funct3`, `mem_addr`=`req_addr`, `mem_wdata`=`req_wdata`.
- Misaligned access with `SPLIT_EN`=1: N=2 (H/HU) or 4 (W).
  - Beat i: `mem_addr`=`req_addr`+i (mod 2^32).
  - Stores: `mem_funct3`=000, `mem_wdata`={24'b0, wdata[8i+7:8i]}.
  - Loads: `mem_funct3`=100.
- Fault: illegal funct3 (011, 110, 111; also 100/101 with store), or misaligned with `SPLIT_EN`=0. Go IDLE→RESP directly with `resp_fault`=1 and no mem strobe.
- ACCESS: assert exactly one of `mem_read`/`mem_write` for one cycle.
  - Store: if i<N-1, stay in ACCESS with i+1; otherwise go to RESP.
  - Load: go to CAPTURE.
- CAPTURE: sample `mem_rdata`.
  - Aligned: keep the whole word.
  - Split: write byte `mem_rdata[7:0]` into assembly lane i.
  - Then go to ACCESS with i+1 if i<N-1, else RESP.
- RESP: `resp_valid`=1, `req_ready`=0; return to IDLE.
  - Aligned loads pass `mem_rdata` unchanged.
  - Split loads are extended: LH sign bit 15, LHU zero, LW as-is.
- Partial stores are not rolled back on reset.

## Timing
- Handshake at cycle T.
- Aligned store: `mem_write` at T+1, `resp_valid` at T+2.
- Aligned load: `mem_read` at T+1, capture at T+2, `resp_valid` at T+3.
- Split store: `mem_write` T+1..T+N, `resp_valid` T+N+1.
- Split load: `mem_read` at T+1, T+3, …; `resp_valid` at T+2N+1 (misaligned LW = T+9).
- Fault: `resp_valid`=`resp_fault`=1 at T+1.
- Between requests, `req_ready` returns to 1 the cycle after RESP.
- `mem_read`/`mem_write` are never asserted together, and are low outside ACCESS.
- Reset values: state IDLE, `req_ready`=1, `resp_valid`=0, `resp_rdata`=0, `resp_fault`=0, all `mem_*` outputs 0.
- `rst` mid-operation drops `mem_read`/`mem_write` immediately (asynchronous) and discards the request.

## Structure
- `lsu_pkg`: funct3 constants (`F3_LB`…`F3_LHU`), state enum, beat-count function.
- One sub-module, `lsu_load_extend`: combinational sign/zero extension of the assembled load word by funct3.

## Test plan
- SW 0xDEADBEEF @0x0, then LW @0x0:
  - `mem_write` high exactly one cycle.
  - `resp_rdata`=0xDEADBEEF at T+3, `resp_fault`=0.
- SH 0xBEEF @0x3:
  - Two SB beats: addr 0x3 data 0xEF, addr 0x4 data 0xBE.
  - LH @0x3 → 0xFFFFBEEF; LHU @0x3 → 0x0000BEEF, each at T+5.
- SW 0x12345678 @0x5:
  - Four byte beats 0x78/0x56/0x34/0x12 at 0x5–0x8.
  - LW @0x5 → 0x12345678 at T+9.
- Faults:
  - funct3 011 load → `resp_fault`=1 at T+1, no mem strobe.
  - `SPLIT_EN`=0, LW @0x2 → fault at T+1, no strobe.
- Reset during SW @0x1 after 2 beats:
  - `mem_write` drops asynchronously; `req_ready`=1 after release.
  - Only bytes 0x1–0x2 modified.
- SH 0xA55A @0xFFFFFFFF: beats at 0xFFFFFFFF (0x5A) then 0x00000000 (0xA5).

Source files
------------

// File: rtl/lsu_pkg.sv
`default_nettype none
//==============================================================================
// Module   : lsu_pkg
// Brief    : Shared definitions for the load/store unit: RV32I funct3 codes,
//            FSM state type and request classification helpers.
// Revision : 1.0 - initial release
//==============================================================================
package lsu_pkg;

    // RV32I load/store width and sign codes
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } lsu_state_t;

    // Halfwords need an even address, words a 4-byte aligned one; bytes never misalign.
    function automatic logic lsu_is_misaligned(input logic [2:0] funct3,
                                               input logic [1:0] addr_lsb);
        logic r;
        case (funct3)
            F3_LH, F3_LHU: r = addr_lsb[0];
            F3_LW:         r = (addr_lsb != 2'b00);
            default:       r = 1'b0;
        endcase
        return r;
    endfunction

    // Undefined codes, and unsigned variants which have no store counterpart.
    function automatic logic lsu_is_illegal(input logic [2:0] funct3,
                                            input logic       is_store);
        logic r;
        case (funct3)
            F3_LB, F3_LH, F3_LW: r = 1'b0;
            F3_LBU, F3_LHU:      r = is_store;
            default:             r = 1'b1;
        endcase
        return r;
    endfunction

    // Beat count minus one (index of the final beat): 0 for a single aligned beat,
    // 1 for a split halfword, 3 for a split word.
    function automatic logic [1:0] lsu_last_beat(input logic [2:0] funct3,
                                                 input logic       split);
        logic [1:0] r;
        if (!split)
            r = 2'd0;
        else if (funct3 == F3_LW)
            r = 2'd3;
        else
            r = 2'd1;
        return r;
    endfunction

endpackage : lsu_pkg
`default_nettype wire

// File: rtl/lsu_load_extend.sv
`default_nettype none
//==============================================================================
// Module   : lsu_load_extend
// Brief    : Combinational sign/zero extension of an assembled load word,
//            selected by the load's funct3.
// Revision : 1.0 - initial release
//==============================================================================
module lsu_load_extend
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [31:0] word,
    output logic [31:0] ext
);

    // Width/sign selection; a full word passes unchanged
    always_comb begin
        ext = word;
        case (funct3)
            F3_LB:   ext = {{24{word[7]}},  word[7:0]};
            F3_LBU:  ext = {24'd0,          word[7:0]};
            F3_LH:   ext = {{16{word[15]}}, word[15:0]};
            F3_LHU:  ext = {16'd0,          word[15:0]};
            default: ext = word;
        endcase
    end

endmodule : lsu_load_extend
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
//==============================================================================
// Module   : load_store_unit
// Brief    : MEM-stage load/store unit in front of DataMemory. Aligned accesses
//            go out as one beat; misaligned H/W accesses are split into byte
//            beats and loads are reassembled and extended. One-cycle response.
// Revision : 1.0 - initial release
//==============================================================================
module load_store_unit
    import lsu_pkg::*;
#(
    parameter bit SPLIT_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_is_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_fault,
    output logic        mem_read,
    output logic        mem_write,
    output logic [2:0]  mem_funct3,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic c_split_en = SPLIT_EN;

    lsu_state_t  r_state;
    logic        r_is_store;
    logic [2:0]  r_funct3;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_asm;
    logic [1:0]  r_beat;
    logic [1:0]  r_last;
    logic        r_split;

    logic        w_handshake;
    logic        w_misaligned;
    logic        w_split;
    logic        w_fault;
    logic [1:0]  w_next_beat;
    logic [31:0] w_next_addr;
    logic [7:0]  w_next_byte;
    logic [31:0] w_asm_next;
    logic [31:0] w_ext;
    logic [31:0] w_load_result;

    assign w_handshake  = req_valid & req_ready;
    assign w_misaligned = lsu_is_misaligned(req_funct3, req_addr[1:0]);
    assign w_split      = w_misaligned & c_split_en;
    assign w_fault      = lsu_is_illegal(req_funct3, req_is_store) | (w_misaligned & ~c_split_en);

    // Next byte beat: address wraps naturally at 2^32
    assign w_next_beat  = r_beat + 2'd1;
    assign w_next_addr  = r_addr + {30'd0, w_next_beat};
    assign w_next_byte  = r_wdata[{w_next_beat, 3'b000} +: 8];

    // Assembly word including the data returned this cycle, so the last
    // captured byte is already visible to the extender when leaving CAPTURE
    always_comb begin
        w_asm_next = r_asm;
        if (r_split)
            w_asm_next[{r_beat, 3'b000} +: 8] = mem_rdata[7:0];
        else
            w_asm_next = mem_rdata;
    end

    lsu_load_extend u_load_extend (
        .funct3 (r_funct3),
        .word   (w_asm_next),
        .ext    (w_ext)
    );

    // DataMemory already extends aligned loads; only split loads need it here
    assign w_load_result = r_split ? w_ext : mem_rdata;

    // Request FSM with all handshake and memory-port outputs registered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_is_store <= 1'b0;
            r_funct3   <= 3'd0;
            r_addr     <= 32'd0;
            r_wdata    <= 32'd0;
            r_asm      <= 32'd0;
            r_beat     <= 2'd0;
            r_last     <= 2'd0;
            r_split    <= 1'b0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_fault <= 1'b0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            mem_funct3 <= 3'd0;
            mem_addr   <= 32'd0;
            mem_wdata  <= 32'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_handshake) begin
                        req_ready  <= 1'b0;
                        r_is_store <= req_is_store;
                        r_funct3   <= req_funct3;
                        r_addr     <= req_addr;
                        r_wdata    <= req_wdata;
                        r_split    <= w_split;
                        r_beat     <= 2'd0;
                        r_last     <= lsu_last_beat(req_funct3, w_split);
                        r_asm      <= 32'd0;
                        if (w_fault) begin
                            resp_valid <= 1'b1;
                            resp_fault <= 1'b1;
                            resp_rdata <= 32'd0;
                            r_state    <= RESP;
                        end else begin
                            mem_read  <= ~req_is_store;
                            mem_write <= req_is_store;
                            mem_addr  <= req_addr;
                            if (w_split) begin
                                mem_funct3 <= req_is_store ? F3_LB : F3_LBU;
                                mem_wdata  <= req_is_store ? {24'd0, req_wdata[7:0]} : 32'd0;
                            end else begin
                                mem_funct3 <= req_funct3;
                                mem_wdata  <= req_wdata;
                            end
                            r_state <= ACCESS;
                        end
                    end
                end

                ACCESS: begin
                    mem_read  <= 1'b0;
                    mem_write <= 1'b0;
                    if (r_is_store) begin
                        if (r_beat != r_last) begin
                            r_beat    <= w_next_beat;
                            mem_write <= 1'b1;
                            mem_addr  <= w_next_addr;
                            mem_wdata <= {24'd0, w_next_byte};
                        end else begin
                            resp_valid <= 1'b1;
                            resp_rdata <= 32'd0;
                            r_state    <= RESP;
                        end
                    end else begin
                        r_state <= CAPTURE;
                    end
                end

                CAPTURE: begin
                    r_asm <= w_asm_next;
                    if (r_beat != r_last) begin
                        r_beat   <= w_next_beat;
                        mem_read <= 1'b1;
                        mem_addr <= w_next_addr;
                        r_state  <= ACCESS;
                    end else begin
                        resp_valid <= 1'b1;
                        resp_rdata <= w_load_result;
                        r_state    <= RESP;
                    end
                end

                RESP: begin
                    resp_valid <= 1'b0;
                    resp_fault <= 1'b0;
                    resp_rdata <= 32'd0;
                    req_ready  <= 1'b1;
                    r_state    <= IDLE;
                end

                default: r_state <= IDLE;
            endcase
        end
    end

endmodule : load_store_unit
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
//==============================================================================
// Module   : tb_load_store_unit
// Brief    : Self-checking bench for load_store_unit with a byte-addressed
//            DataMemory model and a response scoreboard.
// Revision : 1.0 - initial release
//==============================================================================
`define CHK(name, obs, exp) \
    begin \
        n_tests++; \
        assert ((obs) === (exp)) else begin \
            n_fail++; \
            $error("FAIL %s.%s: observed 0x%0h expected 0x%0h", cur_tag, name, (obs), (exp)); \
        end \
    end

module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_is_store = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        req_ready, resp_valid, resp_fault;
    logic [31:0] resp_rdata;
    logic        mem_read, mem_write;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = 32'd0;

    // Second instance with splitting disabled
    logic        ns_req_valid = 1'b0;
    logic        ns_req_ready, ns_resp_valid, ns_resp_fault;
    logic [31:0] ns_resp_rdata;
    logic        ns_mem_read, ns_mem_write;
    logic [2:0]  ns_mem_funct3;
    logic [31:0] ns_mem_addr, ns_mem_wdata;

    int    n_tests = 0;
    int    n_fail  = 0;
    string cur_tag = "init";

    typedef struct {
        logic [31:0] rdata;
        logic        fault;
    } resp_t;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [2:0]  f3;
    } beat_t;

    resp_t sb_q[$];
    beat_t exp_beats[$];
    beat_t got_beats[$];

    always #5 clk = ~clk;

    load_store_unit #(.SPLIT_EN(1'b1)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_fault(resp_fault),
        .mem_read(mem_read), .mem_write(mem_write), .mem_funct3(mem_funct3),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    load_store_unit #(.SPLIT_EN(1'b0)) dut_ns (
        .clk(clk), .rst(rst),
        .req_valid(ns_req_valid), .req_ready(ns_req_ready), .req_is_store(req_is_store),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(ns_resp_valid), .resp_rdata(ns_resp_rdata), .resp_fault(ns_resp_fault),
        .mem_read(ns_mem_read), .mem_write(ns_mem_write), .mem_funct3(ns_mem_funct3),
        .mem_addr(ns_mem_addr), .mem_wdata(ns_mem_wdata), .mem_rdata(32'd0)
    );

    // DataMemory model: byte-addressed, unwritten bytes read as zero, 1-cycle read
    logic [7:0] mem [logic [31:0]];

    function automatic logic [7:0] rd_byte(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 8'h00;
    endfunction

    always @(posedge clk) begin
        logic [7:0] b0, b1, b2, b3;
        if (mem_write) begin
            mem[mem_addr] = mem_wdata[7:0];
            if (mem_funct3[1:0] != 2'b00) mem[mem_addr + 32'd1] = mem_wdata[15:8];
            if (mem_funct3[1:0] == 2'b10) begin
                mem[mem_addr + 32'd2] = mem_wdata[23:16];
                mem[mem_addr + 32'd3] = mem_wdata[31:24];
            end
        end
        if (mem_read) begin
            b0 = rd_byte(mem_addr);
            b1 = rd_byte(mem_addr + 32'd1);
            b2 = rd_byte(mem_addr + 32'd2);
            b3 = rd_byte(mem_addr + 32'd3);
            case (mem_funct3)
                3'b000:  mem_rdata <= {{24{b0[7]}}, b0};
                3'b100:  mem_rdata <= {24'd0, b0};
                3'b001:  mem_rdata <= {{16{b1[7]}}, b1, b0};
                3'b101:  mem_rdata <= {16'd0, b1, b0};
                default: mem_rdata <= {b3, b2, b1, b0};
            endcase
        end
    end

    // Scoreboard: every response is checked against the oldest expectation
    always @(negedge clk) begin
        resp_t e;
        if (!rst && resp_valid) begin
            if (sb_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $error("FAIL %s.unexpected_resp: observed resp_valid 1 expected none", cur_tag);
            end else begin
                e = sb_q.pop_front();
                `CHK("resp_rdata", resp_rdata, e.rdata)
                `CHK("resp_fault", resp_fault, e.fault)
            end
        end
    end

    function automatic void eb(input logic wr, input logic [31:0] a,
                               input logic [31:0] d, input logic [2:0] f3);
        beat_t b;
        b.wr = wr; b.addr = a; b.data = d; b.f3 = f3;
        exp_beats.push_back(b);
    endfunction

    // One request: check ready, drive handshake, record memory beats, check latency
    task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] exp_rd,
                          input logic exp_fault, input int exp_lat, input string tag);
        int    lat;
        logic  both;
        resp_t r;
        beat_t b;
        cur_tag = tag;
        @(negedge clk);
        `CHK("req_ready", req_ready, 1'b1)
        req_valid = 1'b1; req_is_store = st; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        r.rdata = exp_rd; r.fault = exp_fault;
        sb_q.push_back(r);
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0; both = 1'b0;
        got_beats.delete();
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (mem_read && mem_write) both = 1'b1;
            if (mem_read || mem_write) begin
                b.wr = mem_write; b.addr = mem_addr; b.data = mem_wdata; b.f3 = mem_funct3;
                got_beats.push_back(b);
            end
            if (resp_valid) begin
                lat = k;
                break;
            end
        end
        `CHK("latency", lat, exp_lat)
        `CHK("rd_wr_overlap", both, 1'b0)
        `CHK("beat_count", got_beats.size(), exp_beats.size())
        for (int i = 0; i < got_beats.size() && i < exp_beats.size(); i++) begin
            `CHK("beat_wr", got_beats[i].wr, exp_beats[i].wr)
            `CHK("beat_addr", got_beats[i].addr, exp_beats[i].addr)
            `CHK("beat_f3", got_beats[i].f3, exp_beats[i].f3)
            if (exp_beats[i].wr)
                `CHK("beat_wdata", got_beats[i].data, exp_beats[i].data)
        end
        exp_beats.delete();
    endtask

    initial begin
        // Reset state
        cur_tag = "reset";
        repeat (3) @(negedge clk);
        `CHK("req_ready", req_ready, 1'b1)
        `CHK("resp_valid", resp_valid, 1'b0)
        `CHK("resp_rdata", resp_rdata, 32'd0)
        `CHK("resp_fault", resp_fault, 1'b0)
        `CHK("mem_read", mem_read, 1'b0)
        `CHK("mem_write", mem_write, 1'b0)
        `CHK("mem_funct3", mem_funct3, 3'd0)
        `CHK("mem_addr", mem_addr, 32'd0)
        `CHK("mem_wdata", mem_wdata, 32'd0)
        rst = 1'b0;

        // Aligned word store then load
        eb(1, 32'h0, 32'hDEADBEEF, 3'b010);
        do_req(1, 3'b010, 32'h0, 32'hDEADBEEF, 32'h0, 0, 2, "sw_aligned");
        eb(0, 32'h0, 32'h0, 3'b010);
        do_req(0, 3'b010, 32'h0, 32'h0, 32'hDEADBEEF, 0, 3, "lw_aligned");

        // Misaligned halfword store and signed/unsigned loads
        eb(1, 32'h3, 32'h000000EF, 3'b000);
        eb(1, 32'h4, 32'h000000BE, 3'b000);
        do_req(1, 3'b001, 32'h3, 32'h0000BEEF, 32'h0, 0, 3, "sh_split");
        eb(0, 32'h3, 32'h0, 3'b100);
        eb(0, 32'h4, 32'h0, 3'b100);
        do_req(0, 3'b001, 32'h3, 32'h0, 32'hFFFFBEEF, 0, 5, "lh_split");
        eb(0, 32'h3, 32'h0, 3'b100);
        eb(0, 32'h4, 32'h0, 3'b100);
        do_req(0, 3'b101, 32'h3, 32'h0, 32'h0000BEEF, 0, 5, "lhu_split");

        // Aligned signed byte load passes DataMemory's extension through
        eb(0, 32'h4, 32'h0, 3'b000);
        do_req(0, 3'b000, 32'h4, 32'h0, 32'hFFFFFFBE, 0, 3, "lb_aligned");

        // Misaligned word store and load
        eb(1, 32'h5, 32'h78, 3'b000);
        eb(1, 32'h6, 32'h56, 3'b000);
        eb(1, 32'h7, 32'h34, 3'b000);
        eb(1, 32'h8, 32'h12, 3'b000);
        do_req(1, 3'b010, 32'h5, 32'h12345678, 32'h0, 0, 5, "sw_split");
        for (int i = 5; i <= 8; i++) eb(0, 32'(i), 32'h0, 3'b100);
        do_req(0, 3'b010, 32'h5, 32'h0, 32'h12345678, 0, 9, "lw_split");

        // Illegal funct3 faults: no memory traffic, response next cycle
        do_req(0, 3'b011, 32'h0, 32'h0, 32'h0, 1, 1, "fault_f3_011");
        do_req(1, 3'b100, 32'h0, 32'h0, 32'h0, 1, 1, "fault_store_bu");

        // Splitting disabled: misaligned word load faults
        cur_tag = "nosplit_lw";
        @(negedge clk);
        `CHK("req_ready", ns_req_ready, 1'b1)
        ns_req_valid = 1'b1; req_is_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h2;
        @(posedge clk);
        #1 ns_req_valid = 1'b0;
        @(negedge clk);
        `CHK("resp_valid", ns_resp_valid, 1'b1)
        `CHK("resp_fault", ns_resp_fault, 1'b1)
        `CHK("resp_rdata", ns_resp_rdata, 32'd0)
        `CHK("mem_strobe", {ns_mem_read, ns_mem_write}, 2'b00)
        @(negedge clk);
        `CHK("resp_valid_after", ns_resp_valid, 1'b0)
        `CHK("mem_strobe_after", {ns_mem_read, ns_mem_write}, 2'b00)
        `CHK("mem_fields", {ns_mem_funct3, ns_mem_addr, ns_mem_wdata}, 67'd0)

        // Reset in the middle of a split store
        eb(1, 32'h0, 32'hAAAAAAAA, 3'b010);
        do_req(1, 3'b010, 32'h0, 32'hAAAAAAAA, 32'h0, 0, 2, "prefill0");
        eb(1, 32'h4, 32'hBBBBBBBB, 3'b010);
        do_req(1, 3'b010, 32'h4, 32'hBBBBBBBB, 32'h0, 0, 2, "prefill4");
        cur_tag = "reset_mid_store";
        @(negedge clk);
        req_valid = 1'b1; req_is_store = 1'b1; req_funct3 = 3'b010;
        req_addr = 32'h1; req_wdata = 32'hCCDDEEFF;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        `CHK("beat1_addr", {mem_write, mem_addr}, {1'b1, 32'h1})
        @(negedge clk);
        `CHK("beat2_addr", {mem_write, mem_addr}, {1'b1, 32'h2})
        @(posedge clk);
        #2;
        `CHK("beat3_active", mem_write, 1'b1)
        rst = 1'b1;
        #1;
        `CHK("mem_write_async", mem_write, 1'b0)
        `CHK("mem_read_async", mem_read, 1'b0)
        `CHK("req_ready_async", req_ready, 1'b1)
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        `CHK("req_ready_release", req_ready, 1'b1)
        `CHK("resp_valid_release", resp_valid, 1'b0)
        eb(0, 32'h0, 32'h0, 3'b010);
        do_req(0, 3'b010, 32'h0, 32'h0, 32'hAAEEFFAA, 0, 3, "after_reset_lw0");
        eb(0, 32'h4, 32'h0, 3'b010);
        do_req(0, 3'b010, 32'h4, 32'h0, 32'hBBBBBBBB, 0, 3, "after_reset_lw4");

        // Split halfword wrapping past the top of the address space
        eb(1, 32'hFFFFFFFF, 32'h5A, 3'b000);
        eb(1, 32'h00000000, 32'hA5, 3'b000);
        do_req(1, 3'b001, 32'hFFFFFFFF, 32'h0000A55A, 32'h0, 0, 3, "sh_wrap");
        eb(0, 32'hFFFFFFFF, 32'h0, 3'b100);
        eb(0, 32'h00000000, 32'h0, 3'b100);
        do_req(0, 3'b101, 32'hFFFFFFFF, 32'h0, 32'h0000A55A, 0, 5, "lhu_wrap");
        eb(0, 32'hFFFFFFFF, 32'h0, 3'b100);
        eb(0, 32'h00000000, 32'h0, 3'b100);
        do_req(0, 3'b001, 32'hFFFFFFFF, 32'h0, 32'hFFFFA55A, 0, 5, "lh_wrap");

        cur_tag = "drain";
        repeat (2) @(negedge clk);
        `CHK("scoreboard_empty", sb_q.size(), 0)

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global time bound
    initial begin
        #200000;
        $display("FAIL watchdog: observed no completion expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_load_store_unit

`undef CHK
`default_nettype wire
